// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
//
// Command-driven master for a simple synchronous-write / combinational-read
// memory. One command is taken at a time. The possible commands are:
//   00 read burst   : cmd_len+1 beats streamed out on the rd_* channel
//   01 single write : one word written at cmd_addr
//   10 fill burst   : cmd_len+1 consecutive words written with cmd_data
//   11 no-op        : accepted and dropped
// Burst addresses increment and wrap modulo 2**ADDR_WIDTH.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                command opcode
//   cmd_addr              burst start address
//   cmd_len               burst beats minus one
//   cmd_data              write / fill value
//   rd_valid/rd_ready     read beat handshake
//   rd_data               read beat data
//   rd_last               final beat of a read burst
//   busy                  high while a command is being executed
//   mem_we                memory write enable
//   mem_addr              memory address
//   mem_data              memory write data
//   mem_out               memory read data (combinational from mem_addr)
// -----------------------------------------------------------------------------
module mem_master #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2,
    READ  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] data;

  // A read beat may be captured when the output register is empty or its
  // current contents are being consumed on this same edge.
  logic rd_take;
  logic last_beat;

  assign rd_take   = !rd_valid || rd_ready;
  assign last_beat = (cnt == '0);

  // A pending read beat blocks new commands so that rd_valid of one burst can
  // never overlap with the next command's activity.
  assign cmd_ready = (state == IDLE) && !rd_valid;

  assign mem_addr  = cur_addr;
  assign mem_data  = data;

  // NOTE: every register below is updated with <= so that all of them sample
  // the same pre-edge values; mixing in = here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_addr <= '0;
      cnt      <= '0;
      data     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      busy     <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Drain the final beat of the previous burst; rd_data keeps its value.
          if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
          end

          if (cmd_valid && cmd_ready) begin
            cur_addr <= cmd_addr;
            cnt      <= cmd_len;
            data     <= cmd_data;
            case (cmd_op)
              OP_WRITE: begin
                state  <= WRITE;
                busy   <= 1'b1;
                mem_we <= 1'b1;
              end
              OP_FILL: begin
                state  <= FILL;
                busy   <= 1'b1;
                mem_we <= 1'b1;
              end
              OP_READ: begin
                state  <= READ;
                busy   <= 1'b1;
              end
              default: begin
                // No-op: nothing beyond the operand latch happens.
              end
            endcase
          end
        end

        WRITE: begin
          // Single beat: the write happened on this edge.
          state  <= IDLE;
          busy   <= 1'b0;
          mem_we <= 1'b0;
        end

        FILL: begin
          cur_addr <= cur_addr + ADDR_WIDTH'(1);
          cnt      <= cnt - LEN_WIDTH'(1);
          if (last_beat) begin
            state  <= IDLE;
            busy   <= 1'b0;
            mem_we <= 1'b0;
          end
        end

        READ: begin
          // Under backpressure nothing moves, so no beat is lost or repeated.
          if (rd_take) begin
            rd_data  <= mem_out;
            rd_valid <= 1'b1;
            rd_last  <= last_beat;
            cur_addr <= cur_addr + ADDR_WIDTH'(1);
            cnt      <= cnt - LEN_WIDTH'(1);
            if (last_beat) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// -----------------------------------------------------------------------------
// tb_mem_master
//
// Self-checking bench for mem_master. A memory array sits on the mem_* port.
// A command-level model predicts the exact sequence of memory writes and read
// beats for every accepted command. One monitor compares the DUT against that
// prediction on every cycle. Directed scenarios pin the model with literal
// values, then a randomized command stream exercises the rest.
// -----------------------------------------------------------------------------
module tb_mem_master;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int LW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out;

  mem_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_out   (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- memory
  logic [DW-1:0] tb_mem    [DEPTH];
  logic [DW-1:0] model_mem [DEPTH];
  logic          load_mem;

  assign mem_out = tb_mem[mem_addr];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= model_mem[i];
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_data;
    end
  end

  // ---------------------------------------------------------------- scoring
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [DW-1:0] data; logic last; } beat_t;

  wr_t   exp_wr[$];
  beat_t exp_rd[$];
  beat_t rd_log[$];

  // Everything a command will do is known at acceptance time: commands never
  // overlap, so a read sees all writes of earlier commands.
  function automatic void model_accept(input logic [1:0] op, input logic [AW-1:0] addr,
                                       input logic [LW-1:0] len, input logic [DW-1:0] data);
    logic [AW-1:0] a;
    case (op)
      2'b00: for (int i = 0; i <= int'(len); i++) begin
        a = AW'(int'(addr) + i);
        exp_rd.push_back('{data: model_mem[a], last: (i == int'(len))});
      end
      2'b01: begin
        exp_wr.push_back('{addr: addr, data: data});
        model_mem[addr] = data;
      end
      2'b10: for (int i = 0; i <= int'(len); i++) begin
        a = AW'(int'(addr) + i);
        exp_wr.push_back('{addr: a, data: data});
        model_mem[a] = data;
      end
      default: ;
    endcase
  endfunction

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== model_mem[i]) d++;
    return d;
  endfunction

  // ---------------------------------------------------------------- rd_ready driver
  // 0: always ready, 1: random, 2: toggle, 3: driven by the main sequence
  int rd_mode = 0;

  initial begin
    forever begin
      @(negedge clk);
      case (rd_mode)
        0: rd_ready = 1'b1;
        1: rd_ready = 1'($urandom_range(0, 1));
        2: rd_ready = !rd_ready;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- monitor
  initial begin
    bit            hold_prev = 0;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    logic [AW-1:0] hold_addr;
    wr_t           w;
    beat_t         b;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        hold_prev = 0;
        continue;
      end
      if (hold_prev) begin
        check("hold_valid", rd_valid, 1'b1);
        check("hold_data", rd_data, hold_data);
        check("hold_last", rd_last, hold_last);
        check("hold_addr", mem_addr, hold_addr);
      end
      hold_prev = rd_valid && !rd_ready;
      hold_data = rd_data;
      hold_last = rd_last;
      hold_addr = mem_addr;

      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", mem_addr, 64'hFFFF_FFFF);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", mem_addr, w.addr);
          check("wr_data", mem_data, w.data);
        end
      end

      if (rd_valid && rd_ready) begin
        rd_log.push_back('{data: rd_data, last: rd_last});
        if (exp_rd.size() == 0) begin
          check("unexpected_beat", rd_data, 64'hFFFF_FFFF);
        end else begin
          b = exp_rd.pop_front();
          check("rd_data", rd_data, b.data);
          check("rd_last", rd_last, b.last);
        end
      end

      if (!busy) check("we_when_idle", mem_we, 1'b0);
      check("cmd_ready_rule", cmd_ready, !busy && !rd_valid);
    end
  end

  // ---------------------------------------------------------------- helpers
  // Offers a command at a falling edge, holds it until accepted and returns
  // just after the accepting rising edge.
  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [LW-1:0] len, input logic [DW-1:0] data);
    int waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_data  = data;
    while (!cmd_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      check("accept_timeout", waited, 0);
    end else begin
      model_accept(op, addr, len, data);
      @(posedge clk);
    end
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (!(cmd_ready && !busy) && waited < 500);
    if (!(cmd_ready && !busy)) check("idle_timeout", waited, 0);
  endtask

  task automatic wait_rd_valid();
    int waited = 0;
    do begin
      @(negedge clk);
      #1;
      waited++;
    end while (!rd_valid && waited < 50);
    if (!rd_valid) check("rd_valid_timeout", waited, 0);
  endtask

  task automatic observe(input int n, output int we_n, output int busy_n, output int rv_n);
    we_n = 0; busy_n = 0; rv_n = 0;
    repeat (n) begin
      @(negedge clk);
      #1;
      if (mem_we)   we_n++;
      if (busy)     busy_n++;
      if (rd_valid) rv_n++;
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    int            we_n, busy_n, rv_n;
    logic [DW-1:0] d0;
    logic [AW-1:0] a0;
    logic [DW-1:0] snap [DEPTH];

    rst_n     = 1'b0;
    load_mem  = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_data  = '0;
    rd_ready  = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = DW'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    load_mem = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 16'h0);
    check("rst_rd_last", rd_last, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 6'd0);
    check("rst_mem_data", mem_data, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write then single-beat read of the same word.
    send_cmd(2'b01, 6'd5, 4'd0, 16'hBEEF);
    observe(4, we_n, busy_n, rv_n);
    check("wr_we_cycles", we_n, 1);
    check("wr_busy_cycles", busy_n, 1);
    check("wr_mem5", tb_mem[5], 16'hBEEF);
    rd_mode = 3;
    @(negedge clk);
    rd_ready = 1'b0;
    send_cmd(2'b00, 6'd5, 4'd0, 16'h0);
    wait_rd_valid();
    check("rd1_data", rd_data, 16'hBEEF);
    check("rd1_last", rd_last, 1'b1);
    @(negedge clk);
    rd_ready = 1'b1;
    wait_idle();

    // Fill across the top of the address space.
    rd_mode = 0;
    send_cmd(2'b10, 6'd62, 4'd3, 16'h1234);
    observe(8, we_n, busy_n, rv_n);
    check("fill_we_cycles", we_n, 4);
    check("fill_busy_cycles", busy_n, 4);
    check("fill_mem62", tb_mem[62], 16'h1234);
    check("fill_mem63", tb_mem[63], 16'h1234);
    check("fill_mem0", tb_mem[0], 16'h1234);
    check("fill_mem1", tb_mem[1], 16'h1234);

    // Eight-beat read with a toggling consumer.
    for (int i = 0; i < 8; i++) send_cmd(2'b01, AW'(i), 4'd0, DW'(16'hA000 + i));
    wait_idle();
    rd_log.delete();
    rd_mode = 2;
    send_cmd(2'b00, 6'd0, 4'd7, 16'h0);
    wait_idle();
    rd_mode = 0;
    check("burst8_beats", rd_log.size(), 8);
    foreach (rd_log[i]) begin
      check("burst8_data", rd_log[i].data, DW'(16'hA000 + i));
      check("burst8_last", rd_log[i].last, (i == 7));
    end

    // Consumer stalls for five cycles after the first beat.
    rd_mode = 3;
    @(negedge clk);
    rd_ready = 1'b0;
    send_cmd(2'b00, 6'd3, 4'd2, 16'h0);
    wait_rd_valid();
    d0 = rd_data;
    a0 = mem_addr;
    check("stall_first_data", d0, 16'hA003);
    check("stall_addr", a0, 6'd4);
    repeat (5) begin
      @(negedge clk);
      #1;
      check("stall_data", rd_data, d0);
      check("stall_valid", rd_valid, 1'b1);
      check("stall_mem_addr", mem_addr, a0);
      check("stall_cmd_ready", cmd_ready, 1'b0);
    end
    @(negedge clk);
    rd_ready = 1'b1;
    wait_idle();
    rd_mode = 0;

    // Reset during a long fill after three beats.
    for (int i = 0; i < DEPTH; i++) snap[i] = model_mem[i];
    send_cmd(2'b10, 6'd10, 4'd15, 16'h5A5A);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = snap[i];
    model_mem[10] = 16'h5A5A;
    model_mem[11] = 16'h5A5A;
    model_mem[12] = 16'h5A5A;
    @(negedge clk);
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_mem_we", mem_we, 1'b0);
    check("arst_mem_addr", mem_addr, 6'd0);
    check("arst_mem_data", mem_data, 16'h0);
    check("arst_rd_valid", rd_valid, 1'b0);
    check("arst_rd_last", rd_last, 1'b0);
    check("arst_rd_data", rd_data, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("arst_cmd_ready", cmd_ready, 1'b1);
    check("arst_mem12", tb_mem[12], 16'h5A5A);
    check("arst_mem13", tb_mem[13], snap[13]);
    check("arst_mem_image", mem_diffs(), 0);

    // No-op command.
    send_cmd(2'b11, 6'd33, 4'd9, 16'hDEAD);
    @(negedge clk);
    #1;
    check("nop_cmd_ready", cmd_ready, 1'b1);
    observe(4, we_n, busy_n, rv_n);
    check("nop_we", we_n, 0);
    check("nop_busy", busy_n, 0);
    check("nop_rd_valid", rv_n, 0);

    // Randomized command stream with a random consumer.
    rd_mode = 1;
    repeat (150) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_cmd(2'($urandom_range(0, 3)), AW'($urandom), LW'($urandom), DW'($urandom));
    end
    rd_mode = 0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("end_wr_pending", exp_wr.size(), 0);
    check("end_rd_pending", exp_rd.size(), 0);
    check("end_mem_image", mem_diffs(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Param ADDR_WIDTH, default 6, memory address width.
REQ-002 Param DATA_WIDTH, default 16, memory word width.
REQ-003 Param LEN_WIDTH, default 4, burst-length field width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge.
REQ-008 cmd_op  in  2  00 read burst, 01 single write, 10 fill burst, 11 no-op.
REQ-009 cmd_addr  in  ADDR_WIDTH  start address.
REQ-010 cmd_len  in  LEN_WIDTH  beats minus one (0 = 1 beat); ignored for 01/11.
REQ-011 cmd_data  in  DATA_WIDTH  write/fill value.
REQ-012 rd_valid  out  1  read beat available.
REQ-013 rd_ready  in  1  consumer takes beat when rd_valid && rd_ready.
REQ-014 rd_data  out  DATA_WIDTH  read beat, registered.
REQ-015 rd_last  out  1  marks final beat of a read burst.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 mem_we  out  1  memory write enable (memory writes on rising edge).
REQ-018 mem_addr  out  ADDR_WIDTH  memory address, driven from internal cur_addr register.
REQ-019 mem_data  out  DATA_WIDTH  memory write data, driven from latched data register.
REQ-020 mem_out  in  DATA_WIDTH  memory read data, combinational from mem_addr.

Function
REQ-021 FSM states IDLE, WRITE, FILL, READ; cmd_ready = (state==IDLE) && !rd_valid.
REQ-022 On acceptance: latch cmd_addr->cur_addr, cmd_len->cnt, cmd_data->data; next state WRITE (01), FILL (10), READ (00), IDLE (11, no memory or rd activity).
REQ-023 WRITE: exactly one cycle mem_we=1 at cur_addr with data; then IDLE.
REQ-024 FILL: mem_we=1 every cycle; cur_addr increments after each beat; cnt decrements; after cnt==0 beat -> IDLE; total cmd_len+1 writes.
REQ-025 Address increment wraps modulo 2**ADDR_WIDTH (max -> 0) in FILL and READ.
REQ-026 mem_we SHALL be 0 in IDLE and READ.
REQ-027 READ: when !rd_valid || rd_ready, rd_data<=mem_out, rd_valid<=1, rd_last<=(cnt==0), cur_addr++, cnt--; otherwise hold all (backpressure, no beat lost or duplicated).
REQ-028 READ: after capturing cnt==0 beat -> IDLE; rd_valid stays high until consumed.
REQ-029 IDLE: rd_valid && rd_ready clears rd_valid and rd_last; rd_data holds.
REQ-030 Latency: command accepted at edge k -> first mem_we cycle / first rd_valid high after edge k+1.
REQ-031 Full-rate read with rd_ready=1: one beat per cycle, L+1 consecutive beats.
REQ-032 cmd_valid while not ready: command not accepted, no side effect; requester holds it.
REQ-033 mem_addr holds last cur_addr in IDLE.

Reset
REQ-034 rst_n low asynchronously forces: state IDLE, cur_addr 0, cnt 0, data 0, rd_valid 0, rd_data 0, rd_last 0, busy 0, mem_we 0.
REQ-035 Reset mid-burst aborts: no further writes or beats after rst_n falls; cmd_ready=1 on first edge after release.

Verification
REQ-036 Write op01 addr 5 data 0xBEEF, then read op00 addr 5 len 0 -> mem_we one cycle at 5; rd_data=0xBEEF, rd_last=1.
REQ-037 Fill op10 addr 62 len 3 data 0x1234 -> writes at 62,63,0,1 on 4 consecutive cycles; busy high 4 cycles.
REQ-038 Read op00 addr 0 len 7, rd_ready toggling 1/0 -> 8 beats in address order 0..7, rd_last only on 8th, none duplicated.
REQ-039 Read len 2 with rd_ready=0 for 5 cycles after first beat -> rd_data/rd_valid/mem_addr stable; cmd_ready=0 until final beat consumed.
REQ-040 rst_n low during fill addr 10 len 15 after 3 beats -> only 10,11,12 written; all outputs at reset values.
REQ-041 op11 accepted -> no mem_we, no rd_valid; cmd_ready high again next cycle.
